benes_cfg_loader: RTL and testbench

Control-side producer for the 32-port Benes interconnect's switch_set interface. It stores up to CFG_DEPTH complete switch configurations (STAGE_NUM words of SWITCH_NUM bits each), written one stage word at a time. On request it replays a selected configuration into a shadow register bank and commits it atomically to the switch_set outputs that drive the Benes network.

---
 rtl/benes_cfg_loader_pkg.sv | 29 ++
 rtl/benes_cfg_loader_mem.sv | 51 +++++
 rtl/benes_cfg_loader.sv | 155 +++++++++++++++
 tb/tb_benes_cfg_loader.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/benes_cfg_loader_pkg.sv
// Shared constants and types for the Benes switch configuration loader.
package benes_cfg_loader_pkg;

    localparam int SIZE        = 32;
    localparam int SWITCH_NUM  = SIZE / 2;
    localparam int STAGE_NUM   = 2 * $clog2(SIZE) - 1;
    localparam int CFG_DEPTH   = 4;
    localparam int CFG_IDX_W   = $clog2(CFG_DEPTH);
    localparam int STAGE_IDX_W = 4;

    typedef logic [SWITCH_NUM-1:0]  switch_word_t;
    typedef logic [CFG_IDX_W-1:0]   cfg_idx_t;
    typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfg_state_e;

    // Highest legal stage index, sized to the stage index field.
    localparam stage_idx_t LAST_STAGE = stage_idx_t'(STAGE_NUM - 1);

    // True when a stage index addresses a real Benes stage.
    function automatic logic stage_in_range(input stage_idx_t stage);
        return stage <= LAST_STAGE;
    endfunction

endpackage

// File: rtl/benes_cfg_loader_mem.sv
// Configuration store: CFG_DEPTH slots of STAGE_NUM switch words, one write
// port and one combinational read port. Out-of-range stage writes match no
// word and are therefore silently dropped.
module benes_cfg_mem
    import benes_cfg_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  cfg_idx_t     wr_cfg,
    input  stage_idx_t   wr_stage,
    input  switch_word_t wr_data,
    input  cfg_idx_t     rd_cfg,
    input  stage_idx_t   rd_stage,
    output switch_word_t rd_data
);

    switch_word_t mem [CFG_DEPTH][STAGE_NUM];

    // Word storage: cleared on reset, one word updated per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CFG_DEPTH; c++) begin
                for (int s = 0; s < STAGE_NUM; s++) begin
                    mem[c][s] <= '0;
                end
            end
        end else if (we) begin
            for (int c = 0; c < CFG_DEPTH; c++) begin
                for (int s = 0; s < STAGE_NUM; s++) begin
                    if (wr_cfg == cfg_idx_t'(c) && wr_stage == stage_idx_t'(s)) begin
                        mem[c][s] <= wr_data;
                    end
                end
            end
        end
    end

    // Read mux; an unmatched stage index reads as zero rather than X.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CFG_DEPTH; c++) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (rd_cfg == cfg_idx_t'(c) && rd_stage == stage_idx_t'(s)) begin
                    rd_data = mem[c][s];
                end
            end
        end
    end

endmodule

// File: rtl/benes_cfg_loader.sv
// Benes switch configuration loader: stores configurations written one stage
// word at a time, replays a chosen slot into a shadow bank and commits the
// whole bank to switch_set on a single edge.
module benes_cfg_loader
    import benes_cfg_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [CFG_IDX_W-1:0]   wr_cfg,
    input  logic [STAGE_IDX_W-1:0] wr_stage,
    input  logic [SWITCH_NUM-1:0]  wr_data,
    input  logic                   apply_valid,
    output logic                   apply_ready,
    input  logic [CFG_IDX_W-1:0]   apply_cfg,
    output logic [SWITCH_NUM-1:0]  switch_set [0:STAGE_NUM-1],
    output logic [CFG_IDX_W-1:0]   cfg_active,
    output logic                   cfg_loaded,
    output logic                   switch_update,
    output logic                   wr_err
);

    cfg_state_e   state;
    cfg_state_e   state_next;
    cfg_idx_t     ld_cfg;
    stage_idx_t   cnt;
    switch_word_t shadow [STAGE_NUM];
    switch_word_t rd_data;
    logic         wr_fire;
    logic         apply_fire;

    benes_cfg_mem u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_fire),
        .wr_cfg   (wr_cfg),
        .wr_stage (wr_stage),
        .wr_data  (wr_data),
        .rd_cfg   (ld_cfg),
        .rd_stage (cnt),
        .rd_data  (rd_data)
    );

    // Handshakes; writes to the slot being replayed are held off so the
    // committed configuration is never a blend of old and new words.
    always_comb begin
        apply_ready = 1'b0;
        wr_ready    = 1'b1;
        if (state == IDLE) begin
            apply_ready = 1'b1;
        end
        if (state != IDLE && wr_cfg == ld_cfg) begin
            wr_ready = 1'b0;
        end
        wr_fire    = wr_valid && wr_ready;
        apply_fire = apply_valid && apply_ready;
    end

    // Next-state logic: IDLE -> LOAD for STAGE_NUM cycles -> COMMIT -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (apply_fire) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cnt == LAST_STAGE) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the requested slot and walk the stage counter through the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cfg <= '0;
            cnt    <= '0;
        end else if (state == IDLE && apply_fire) begin
            ld_cfg <= apply_cfg;
            cnt    <= '0;
        end else if (state == LOAD && cnt != LAST_STAGE) begin
            cnt <= cnt + stage_idx_t'(1);
        end
    end

    // Shadow bank fills one stage per LOAD cycle, invisible to the network.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                shadow[s] <= '0;
            end
        end else if (state == LOAD) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (cnt == stage_idx_t'(s)) begin
                    shadow[s] <= rd_data;
                end
            end
        end
    end

    // Atomic commit of the full shadow bank plus the status that goes with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                switch_set[s] <= '0;
            end
            cfg_active    <= '0;
            cfg_loaded    <= 1'b0;
            switch_update <= 1'b0;
        end else begin
            switch_update <= (state == COMMIT);
            if (state == COMMIT) begin
                for (int s = 0; s < STAGE_NUM; s++) begin
                    switch_set[s] <= shadow[s];
                end
                cfg_active <= ld_cfg;
                cfg_loaded <= 1'b1;
            end
        end
    end

    // Sticky flag for accepted writes that address a nonexistent stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else if (wr_fire && !stage_in_range(wr_stage)) begin
            wr_err <= 1'b1;
        end
    end

    // Simulation-only sanity: the counter stays in range and the update pulse
    // only ever appears once the FSM is back in IDLE.
    assert property (@(posedge clk) disable iff (!rst_n) cnt <= LAST_STAGE);
    assert property (@(posedge clk) disable iff (!rst_n) switch_update |-> state == IDLE);

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Self-checking bench for benes_cfg_loader against a slot/stage array model.
module tb_benes_cfg_loader;
    import benes_cfg_loader_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    cfg_idx_t     wr_cfg;
    stage_idx_t   wr_stage;
    switch_word_t wr_data;
    logic         apply_valid;
    logic         apply_ready;
    cfg_idx_t     apply_cfg;
    switch_word_t switch_set [0:STAGE_NUM-1];
    cfg_idx_t     cfg_active;
    logic         cfg_loaded;
    logic         switch_update;
    logic         wr_err;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words, what the network should see, and the
    // configuration captured at the most recent apply handshake.
    switch_word_t ref_mem [CFG_DEPTH][STAGE_NUM];
    switch_word_t ref_set [STAGE_NUM];
    switch_word_t pend_set [STAGE_NUM];
    int           pend_cfg;
    logic         ref_err;

    benes_cfg_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_cfg        (wr_cfg),
        .wr_stage      (wr_stage),
        .wr_data       (wr_data),
        .apply_valid   (apply_valid),
        .apply_ready   (apply_ready),
        .apply_cfg     (apply_cfg),
        .switch_set    (switch_set),
        .cfg_active    (cfg_active),
        .cfg_loaded    (cfg_loaded),
        .switch_update (switch_update),
        .wr_err        (wr_err)
    );

    always #5 clk = ~clk;

    // Hard stop in case something upstream never terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < CFG_DEPTH; c++)
            for (int s = 0; s < STAGE_NUM; s++)
                ref_mem[c][s] = '0;
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = '0;
        ref_err = 1'b0;
    endtask

    task automatic take_snapshot(input int c);
        pend_cfg = c;
        for (int s = 0; s < STAGE_NUM; s++) pend_set[s] = ref_mem[c][s];
    endtask

    // Drives one stage-word write and waits (bounded) for it to be accepted.
    task automatic do_write(input int c, input int s, input switch_word_t d);
        bit ok = 0;
        wr_cfg   = cfg_idx_t'(c);
        wr_stage = stage_idx_t'(s);
        wr_data  = d;
        wr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_ready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL write_timeout got wr_ready=0 need 1 (cfg %0d stage %0d)", c, s);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        if (ok) begin
            if (s < STAGE_NUM) ref_mem[c][s] = d;
            else ref_err = 1'b1;
        end
    endtask

    // Drives an apply request; returns just after the handshake edge.
    task automatic do_apply(input int c);
        bit ok = 0;
        apply_cfg   = cfg_idx_t'(c);
        apply_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (apply_ready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL apply_timeout got apply_ready=0 need 1 (cfg %0d)", c);
        end
        @(posedge clk);
        #1 apply_valid = 1'b0;
        take_snapshot(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_cfg = '0; wr_stage = '0; wr_data = '0;
        apply_valid = 1'b0; apply_cfg = '0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < STAGE_NUM; s++) begin
            checks++;
            if (switch_set[s] !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_switch_set[%0d] got %h need 0000", s, switch_set[s]);
            end
        end
        checks++;
        if (apply_ready !== 1'b1 || wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got apply=%b wr=%b need 1 1", apply_ready, wr_ready);
        end
        checks++;
        if (cfg_loaded !== 1'b0 || wr_err !== 1'b0 || switch_update !== 1'b0 || cfg_active !== '0) begin
            errors++;
            $display("[TB] FAIL reset_status got loaded=%b err=%b upd=%b act=%0d need 0 0 0 0",
                     cfg_loaded, wr_err, switch_update, cfg_active);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_apply();
        switch_word_t vec [STAGE_NUM];
        logic exp_upd;
        vec = '{16'hA300, 16'h00A8, 16'hE0E4, 16'h183C, 16'h1014,
                16'h1014, 16'h2020, 16'h2810, 16'h2D00};
        for (int s = 0; s < STAGE_NUM; s++) do_write(0, s, vec[s]);
        do_apply(0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (apply_ready !== 1'b0 || switch_update !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_busy[%0d] got ready=%b upd=%b need 0 0", k, apply_ready, switch_update);
            end
            for (int s = 0; s < STAGE_NUM; s++) begin
                checks++;
                if (switch_set[s] !== ref_set[s]) begin
                    errors++;
                    $display("[TB] FAIL basic_early[%0d][%0d] got %h need %h", k, s, switch_set[s], ref_set[s]);
                end
            end
            @(posedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp_upd = (k == 0);
            checks++;
            if (switch_update !== exp_upd || apply_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL basic_pulse[%0d] got upd=%b ready=%b need %b 1", k, switch_update, apply_ready, exp_upd);
            end
        end
        for (int s = 0; s < STAGE_NUM; s++) begin
            checks++;
            if (switch_set[s] !== vec[s]) begin
                errors++;
                $display("[TB] FAIL basic_set[%0d] got %h need %h", s, switch_set[s], vec[s]);
            end
        end
        checks++;
        if (cfg_active !== 2'd0 || cfg_loaded !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_status got act=%0d loaded=%b need 0 1", cfg_active, cfg_loaded);
        end
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
    endtask

    task automatic test_back_to_back();
        int n_old;
        int n_new;
        logic exp_r;
        for (int s = 0; s < STAGE_NUM; s++) do_write(1, s, 16'hFFFF);
        do_apply(0);
        repeat (10) @(posedge clk);
        #1 apply_cfg = 2'd1;
        apply_valid = 1'b1;
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
        @(posedge clk);
        #1 apply_valid = 1'b0;
        take_snapshot(1);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            n_old = 0;
            n_new = 0;
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (switch_set[s] === ref_set[s]) n_old++;
                if (switch_set[s] === pend_set[s]) n_new++;
            end
            checks++;
            if ((k < 10 && n_old != STAGE_NUM) || (k == 10 && n_new != STAGE_NUM)) begin
                errors++;
                $display("[TB] FAIL b2b_atomic[%0d] got old=%0d new=%0d stages need %0d", k, n_old, n_new, STAGE_NUM);
            end
            exp_r = (k == 10);
            checks++;
            if (apply_ready !== exp_r) begin
                errors++;
                $display("[TB] FAIL b2b_ready[%0d] got %b need %b", k, apply_ready, exp_r);
            end
            if (k < 10) @(posedge clk);
        end
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
    endtask

    task automatic test_write_during_load();
        switch_word_t d2;
        bit ok = 0;
        d2 = switch_word_t'($urandom);
        do_apply(1);
        @(posedge clk);
        #1 wr_cfg = 2'd2; wr_stage = 4'd3; wr_data = d2; wr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_other_slot got wr_ready=%b need 1", wr_ready);
        end
        @(posedge clk);
        ref_mem[2][3] = d2;
        #1 wr_cfg = 2'd1; wr_stage = 4'd0; wr_data = 16'h1234;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_same_slot got wr_ready=%b need 0", wr_ready);
        end
        for (int i = 0; i < 30; i++) begin
            if (wr_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || apply_ready !== 1'b1 || switch_update !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release got ok=%0d ready=%b upd=%b need 1 1 1", ok, apply_ready, switch_update);
        end
        for (int s = 0; s < STAGE_NUM; s++) begin
            checks++;
            if (switch_set[s] !== pend_set[s]) begin
                errors++;
                $display("[TB] FAIL stall_commit[%0d] got %h need %h", s, switch_set[s], pend_set[s]);
            end
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        ref_mem[1][0] = 16'h1234;
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
        do_apply(2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < STAGE_NUM; s++) begin
            checks++;
            if (switch_set[s] !== pend_set[s]) begin
                errors++;
                $display("[TB] FAIL slot2_set[%0d] got %h need %h", s, switch_set[s], pend_set[s]);
            end
        end
        checks++;
        if (cfg_active !== 2'd2) begin
            errors++;
            $display("[TB] FAIL slot2_active got %0d need 2", cfg_active);
        end
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
    endtask

    task automatic test_simultaneous();
        switch_word_t d;
        d = switch_word_t'($urandom);
        @(posedge clk);
        #1 wr_cfg = 2'd3; wr_stage = 4'd5; wr_data = d; wr_valid = 1'b1;
        apply_cfg = 2'd3; apply_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || apply_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_ready got wr=%b apply=%b need 1 1", wr_ready, apply_ready);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0; apply_valid = 1'b0;
        ref_mem[3][5] = d;
        take_snapshot(3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < STAGE_NUM; s++) begin
            checks++;
            if (switch_set[s] !== pend_set[s]) begin
                errors++;
                $display("[TB] FAIL simul_set[%0d] got %h need %h", s, switch_set[s], pend_set[s]);
            end
        end
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
    endtask

    task automatic test_bad_stage();
        switch_word_t nw;
        do_write(0, 9, switch_word_t'($urandom));
        @(negedge clk);
        checks++;
        if (wr_err !== ref_err || wr_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_stage9 got %b need 1", wr_err);
        end
        do_write(2, 15, switch_word_t'($urandom));
        do_write(3, 1, switch_word_t'($urandom));
        @(negedge clk);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky got %b need 1", wr_err);
        end
        do_apply(0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < STAGE_NUM; s++) begin
            checks++;
            if (switch_set[s] !== pend_set[s]) begin
                errors++;
                $display("[TB] FAIL err_mem[%0d] got %h need %h", s, switch_set[s], pend_set[s]);
            end
        end
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
        nw = ~ref_mem[0][4];
        do_write(0, 4, nw);
        repeat (3) @(negedge clk);
        checks++;
        if (switch_set[4] !== ref_set[4]) begin
            errors++;
            $display("[TB] FAIL idle_rewrite got %h need %h", switch_set[4], ref_set[4]);
        end
        do_apply(0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (switch_set[4] !== nw) begin
            errors++;
            $display("[TB] FAIL rewrite_apply got %h need %h", switch_set[4], nw);
        end
        for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
    endtask

    task automatic test_random();
        int c;
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < int'($urandom_range(6, 1)); w++)
                do_write(int'($urandom_range(CFG_DEPTH - 1, 0)), int'($urandom_range(STAGE_NUM - 1, 0)),
                         switch_word_t'($urandom));
            c = int'($urandom_range(CFG_DEPTH - 1, 0));
            do_apply(c);
            repeat (10) @(posedge clk);
            @(negedge clk);
            for (int s = 0; s < STAGE_NUM; s++) begin
                checks++;
                if (switch_set[s] !== pend_set[s]) begin
                    errors++;
                    $display("[TB] FAIL rand[%0d]_set[%0d] got %h need %h", it, s, switch_set[s], pend_set[s]);
                end
            end
            checks++;
            if (int'(cfg_active) != c || switch_update !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand[%0d]_status got act=%0d upd=%b need %0d 1", it, cfg_active, switch_update, c);
            end
            for (int s = 0; s < STAGE_NUM; s++) ref_set[s] = pend_set[s];
        end
    endtask

    task automatic test_reset_mid_load();
        do_write(1, 0, 16'h8001);
        do_apply(1);
        repeat (10) @(posedge clk);
        do_apply(0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < STAGE_NUM; s++) begin
            checks++;
            if (switch_set[s] !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL midrst_set[%0d] got %h need 0000", s, switch_set[s]);
            end
        end
        checks++;
        if (apply_ready !== 1'b1 || switch_update !== 1'b0 || cfg_loaded !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_state got ready=%b upd=%b loaded=%b need 1 0 0",
                     apply_ready, switch_update, cfg_loaded);
        end
        model_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (switch_update !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_pulse[%0d] got %b need 0", k, switch_update);
            end
        end
        checks++;
        if (wr_ready !== 1'b1 || wr_err !== 1'b0 || cfg_active !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_status got wr_ready=%b err=%b act=%0d need 1 0 0", wr_ready, wr_err, cfg_active);
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (switch_update !== 1'b0 || switch_set[0] !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midrst_resume got upd=%b set0=%h need 0 0000", switch_update, switch_set[0]);
        end
        do_apply(1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (switch_set[0] !== 16'h0000 || cfg_loaded !== 1'b1 || cfg_active !== 2'd1) begin
            errors++;
            $display("[TB] FAIL midrst_cleared got set0=%h loaded=%b act=%0d need 0000 1 1",
                     switch_set[0], cfg_loaded, cfg_active);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        $display("[TB] reset done");
        test_basic_apply();
        test_back_to_back();
        test_write_during_load();
        test_simultaneous();
        test_bad_stage();
        test_random();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
